// File: rtl/fifo_param_umbral_if.sv
// Push/pop data handshake between the packet source and the threshold FIFO.
// master drives requests and write data; slave returns read data and its qualifier.
interface fifo_param_umbral_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;

  modport master (
    output push, pop, data_in,
    input  data_out, valid_out
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, valid_out
  );
endinterface

// File: rtl/fifo_param_umbral.sv
// Parametrised FIFO with latched almost-full/almost-empty thresholds and a sticky error FSM.
// Defining FIFO_FWFT_EN selects first-word-fall-through; otherwise reads have 1-cycle latency.
module fifo_param_umbral #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_superior,
  input  logic [ADDR_WIDTH:0]   umbral_inferior,
  fifo_param_umbral_if.slave    bus,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count,
  output logic [1:0]            fsm_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [ADDR_WIDTH:0]   sup_q, inf_q, sup_n, inf_n;
  logic [ADDR_WIDTH:0]   cnt_n;
  logic                  do_wr, do_rd, err_n;

  assign fsm_state = state;

  always_comb begin
    state_n = state;
    sup_n   = sup_q;
    inf_n   = inf_q;
    err_n   = error;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    unique case (state)
      S_INIT: begin
        if (init) begin
          sup_n = umbral_superior;
          inf_n = umbral_inferior;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_IDLE: begin
        if (init) begin
          sup_n   = umbral_superior;
          inf_n   = umbral_inferior;
          state_n = S_INIT;
        end else if (bus.pop) begin
          state_n = S_ERROR;
          err_n   = 1'b1;
        end else if (bus.push) begin
          do_wr   = 1'b1;
          state_n = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // push+pop on a full FIFO is a legal swap; only a lone push overflows
        if (bus.push && !bus.pop && full) begin
          state_n = S_ERROR;
          err_n   = 1'b1;
        end else begin
          do_wr = bus.push;
          do_rd = bus.pop;
          if (bus.pop && !bus.push && count == CNT_ONE)
            state_n = S_IDLE;
        end
      end
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_ERROR;
    endcase
  end

  always_comb begin
    cnt_n = count;
    if (do_wr && !do_rd)
      cnt_n = count + CNT_ONE;
    else if (do_rd && !do_wr)
      cnt_n = count - CNT_ONE;
  end

  assign rd_ptr_n = do_rd ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_INIT;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sup_q         <= DEPTH_C - CNT_ONE;
      inf_q         <= CNT_ONE;
      error         <= 1'b0;
      empty         <= 1'b1;
      full          <= 1'b0;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= cnt_n;
      sup_q        <= sup_n;
      inf_q        <= inf_n;
      error        <= err_n;
      rd_ptr       <= rd_ptr_n;
      if (do_wr)
        wr_ptr <= wr_ptr + PTR_ONE;
      empty        <= (cnt_n == '0);
      full         <= (cnt_n == DEPTH_C);
      almost_full  <= (cnt_n >= sup_n);
      almost_empty <= (cnt_n <= inf_n);
`ifdef FIFO_FWFT_EN
      // a word written into an empty slot at the head bypasses the array
      if (do_wr && wr_ptr == rd_ptr_n)
        bus.data_out <= bus.data_in;
      else
        bus.data_out <= mem[rd_ptr_n];
      bus.valid_out <= (cnt_n != '0);
`else
      if (do_rd)
        bus.data_out <= mem[rd_ptr];
      bus.valid_out <= do_rd;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_param_umbral.sv
// Randomised scoreboard bench for fifo_param_umbral against a queue-based model.
// Covers the directed plan, then random push/pop/init/reset rounds.
module tb_fifo_param_umbral;
  localparam int DW = 12;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [AW:0]   us = '0;
  logic [AW:0]   ui = '0;
  logic          empty, full, almost_full, almost_empty, error;
  logic [AW:0]   count;
  logic [1:0]    fsm_state;

  fifo_param_umbral_if #(.DATA_WIDTH(DW)) bus ();

  fifo_param_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_superior (us),
    .umbral_inferior (ui),
    .bus             (bus.slave),
    .empty           (empty),
    .full            (full),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .error           (error),
    .count           (count),
    .fsm_state       (fsm_state)
  );

  always #5 clk = ~clk;

  // reference model: occupancy is a queue, state is a plain integer
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mdout = '0;
  int            mst = 0;
  int            msup = D - 1;
  int            minf = 1;
  bit            merr = 1'b0;
  bit            mvalid = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (reset) begin
      mq.delete();
      sb.delete();
      mst    = 0;
      msup   = D - 1;
      minf   = 1;
      merr   = 1'b0;
      mdout  = '0;
      mvalid = 1'b0;
    end else begin
      mvalid = 1'b0;
      case (mst)
        0: begin
          if (init) begin
            msup = int'(us);
            minf = int'(ui);
          end else mst = 1;
        end
        1: begin
          if (init) begin
            msup = int'(us);
            minf = int'(ui);
            mst  = 0;
          end else if (bus.pop) begin
            mst  = 3;
            merr = 1'b1;
          end else if (bus.push) begin
            mq.push_back(bus.data_in);
            mst = 2;
          end
        end
        2: begin
          if (bus.push && !bus.pop && mq.size() == D) begin
            mst  = 3;
            merr = 1'b1;
          end else begin
            if (bus.pop) begin
              w = mq.pop_front();
`ifndef FIFO_FWFT_EN
              sb.push_back(w);
`endif
              mdout  = w;
              mvalid = 1'b1;
            end
            if (bus.push) mq.push_back(bus.data_in);
            if (mq.size() == 0) mst = 1;
          end
        end
        default: ;
      endcase
`ifdef FIFO_FWFT_EN
      mvalid = (mq.size() != 0);
`endif
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    chk("fsm_state", int'(fsm_state), mst);
    chk("count", int'(count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == D));
    chk("almost_full", int'(almost_full), int'(mq.size() >= msup));
    chk("almost_empty", int'(almost_empty), int'(mq.size() <= minf));
    chk("error", int'(error), int'(merr));
    chk("valid_out", int'(bus.valid_out), int'(mvalid));
`ifdef FIFO_FWFT_EN
    if (bus.valid_out && mq.size() != 0)
      chk("head_data", int'(bus.data_out), int'(mq[0]));
    else if (reset === 1'b0 && mq.size() == 0 && mst == 0)
      chk("data_out_hold", int'(bus.data_out), int'(mdout));
`else
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (bus.valid_out) chk("pop_data", int'(bus.data_out), int'(e));
    end
    chk("data_out_hold", int'(bus.data_out), int'(mdout));
`endif
  end

  task automatic cyc(input bit r, input bit i, input bit ps,
                     input bit pp, input logic [DW-1:0] d);
    reset       = r;
    init        = i;
    bus.push    = ps;
    bus.pop     = pp;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pp_push, pp_pop;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    @(posedge clk);
    #1;
    // plan 1: load thresholds, leave INIT
    us = 4'd6;
    ui = 4'd1;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // plan 2: fill
    for (int k = 1; k <= 8; k++) cyc(0, 0, 1, 0, DW'(k));
    // plan 3: swap while full
    for (int k = 9; k <= 13; k++) cyc(0, 0, 1, 1, DW'(k));
    cyc(0, 0, 0, 0, 0);
    // plan 4: overflow, pop ignored, reset
    cyc(0, 0, 1, 0, 12'h0FF);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // plan 5: three in, four out
    cyc(0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 0, DW'(12'h010 + k));
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // plan 6 sequence (fall-through behaviour is checked by the monitor)
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 12'h0A1);
    cyc(0, 0, 1, 0, 12'h0A2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // random rounds
    for (int r = 0; r < 16; r++) begin
      us = AW'($urandom_range(0, D));
      ui = AW'($urandom_range(0, D));
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) cyc(0, 1, 0, 0, 0);
      pp_push = $urandom_range(50, 85);
      pp_pop  = $urandom_range(15, 70);
      for (int k = 0; k < 150; k++) begin
        cyc($urandom_range(0, 199) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) < pp_push,
            $urandom_range(0, 99) < pp_pop,
            DW'($urandom));
      end
    end
    cyc(0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
